reg_bank: RTL

- 32 x 32-bit general-purpose register file for the multicycle datapath.
- Two combinational read ports feed the A/B operand registers.
- One synchronous write port. Its 5-bit destination address comes directly from the write-register select mux (rt, rd, fixed $29 = sp, fixed $31 = ra), and its write data comes from the write-data mux.
- Register $0 reads as zero. $sp resets to the top-of-stack value used by the rest of the design.

---
 rtl/reg_bank.sv | 61 ++++++
 1 files changed

// File: rtl/reg_bank.sv
// 32 x DATA_W register file: two combinational read ports, one synchronous write port.
// Optional same-cycle write-to-read forwarding is compiled in with REG_BANK_BYPASS_EN.
module reg_bank #(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(227)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write,
    input  logic [4:0]        read_reg1,
    input  logic [4:0]        read_reg2,
    input  logic [4:0]        write_reg,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2
);

    localparam logic [4:0] SP_ADDR = 5'd29;

    // $0 is hardwired to zero, so only 1..31 hold state.
    logic [DATA_W-1:0] regs [31:1];
    logic              wr_en;
    logic [DATA_W-1:0] array_data1;
    logic [DATA_W-1:0] array_data2;

    assign wr_en = reg_write && (write_reg != 5'd0);

    // Reset wins over a write presented in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= (5'(i) == SP_ADDR) ? SP_RESET : '0;
            end
        end else if (wr_en) begin
            regs[write_reg] <= write_data;
        end
    end

    always_comb begin
        array_data1 = '0;
        array_data2 = '0;
        if (read_reg1 != 5'd0) array_data1 = regs[read_reg1];
        if (read_reg2 != 5'd0) array_data2 = regs[read_reg2];
    end

`ifdef REG_BANK_BYPASS_EN
    logic fwd1;
    logic fwd2;

    // Forward only real writes: reset, a disabled write or a $0 target all fall back to the array.
    assign fwd1 = wr_en && !reset && (write_reg == read_reg1);
    assign fwd2 = wr_en && !reset && (write_reg == read_reg2);

    assign read_data1 = fwd1 ? write_data : array_data1;
    assign read_data2 = fwd2 ? write_data : array_data2;
`else
    assign read_data1 = array_data1;
    assign read_data2 = array_data2;
`endif

endmodule
